transformation_unit: RTL
========================

# transformation_unit

Controller and datapath for the GCN feature×weight transformation (FM_WM = FM·WM). It drives the address counter's enables and select, consumes the memory read data that the counter's `read_address` fetches, and computes one dot product per (feature row, weight column). Results go into an on-block FEATURE_ROWS×WEIGHT_COLS result buffer, which the downstream aggregation stage reads.

## Interface
- FEATURE_ROWS, 6, feature matrix rows; must match the address counter
- WEIGHT_COLS, 3, weight matrix columns; must match the address counter
- FEATURE_COLS, 96, elements per memory word (feature row / weight column length)
- DATA_WIDTH, 5, unsigned element width
- DOT_PROD_WIDTH, 16, result width
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS); COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS)

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; shared net with the address counter
- start  in  1  single-cycle pulse; begins a full transformation
- data_in  in  FEATURE_COLS×DATA_WIDTH  memory read data, valid one cycle after the address
- weight_count  in  COUNTER_WEIGHT_WIDTH  from address counter
- read_row  in  COUNTER_FEATURE_WIDTH  from address counter; row of the current `data_in`
- enable_feature_counter  out  1  to counter
- enable_weight_counter  out  1  to counter
- read_feature_or_weight  out  1  1 = feature address, 0 = weight address
- busy  out  1  high from LOAD_W through DRAIN
- done  out  1  high in DONE
- fm_wm_rd_row  in  COUNTER_FEATURE_WIDTH  result read row
- fm_wm_rd_col  in  COUNTER_WEIGHT_WIDTH  result read column
- fm_wm_rd_data  out  DOT_PROD_WIDTH  registered read data

## Operation
- Moore FSM with states IDLE, LOAD_W, LATCH_W, FEAT, DRAIN, DONE.
- IDLE: all enables 0, select 0. `start` moves the FSM to LOAD_W.
- LOAD_W, 1 cycle: select 0, so the address is the weight column at `weight_count`.
- LATCH_W, 1 cycle:
  - `weight_reg <= data_in`, `col_idx <= weight_count`.
  - `enable_weight_counter` = 1 with select 0.
- FEAT, exactly FEATURE_ROWS cycles:
  - select 1, `enable_feature_counter` = 1 every cycle.
  - An internal row counter ends the phase; then go to DRAIN.
- `wr_pending` is `enable_feature_counter` registered. When it is set, the block writes `fm_wm[read_row][col_idx] <= dot(data_in, weight_reg)`. Writes therefore occur on the last FEATURE_ROWS−1 FEAT cycles plus the DRAIN cycle.
- DRAIN, 1 cycle: final write. If `col_idx == WEIGHT_COLS-1` go to DONE, else go to LOAD_W.
- DONE: `done` held high. `start` re-enters LOAD_W; no return to IDLE.
- Dot product arithmetic:
  - Unsigned sum of FEATURE_COLS products, each DATA_WIDTH×DATA_WIDTH.
  - Full-precision internal width is 2·DATA_WIDTH+$clog2(FEATURE_COLS).
  - Reduced to DOT_PROD_WIDTH per Configuration.
- The counter wraps itself, so both of its counts are 0 again after a full run. No explicit counter clear is needed.
- `start` is ignored in LOAD_W, LATCH_W, FEAT and DRAIN.
- Result buffer read port:
  - `fm_wm_rd_data` registered, 1-cycle latency.
  - Out-of-range row or column returns 0.
  - Reading during a run returns the current buffer contents.

## Timing
- Reset values:
  - state IDLE; all enables, select, `busy`, `done` = 0.
  - `fm_wm_rd_data` = 0, every buffer entry = 0.
  - `weight_reg`, `col_idx`, `wr_pending` = 0.
- Reset mid-run: IDLE on the next edge; buffer cleared. The counter is reset by the same net, so the next `start` runs cleanly.
- Each column takes FEATURE_ROWS+3 cycles.
- `done` rises WEIGHT_COLS·(FEATURE_ROWS+3) edges after the edge that samples `start`; 27 with defaults.
- `done` falls on the edge that samples a restart `start`.
- Each buffer entry is visible on the read port 2 edges after its write cycle: 1 edge to write, 1 edge for the registered read.

## Configuration
- `TRANSFORM_SAT_EN` defined: a full-precision sum above 2^DOT_PROD_WIDTH−1 saturates to all ones.
- Not defined: the result is the DOT_PROD_WIDTH LSBs of the sum (wrap).

## Structure
- Shared package `gcn_pkg` holds:
  - state enum `transform_state_t`
  - a function for the full-precision product width
  - default dimension constants shared with the address counter
- Sub-module `dot_product_unit`: combinational, FEATURE_COLS-wide multiply plus adder tree, followed by the wrap/saturate stage. It is the only place the `TRANSFORM_SAT_EN` macro appears.

## Test plan
- Uniform sums: all weights 1, feature row r elements all = r, pulse `start` → `fm_wm[r][c]` = 96·r for all c; `done` 27 edges after `start`.
- Index mapping: element 0 only nonzero, weight col c = c+1, feature row r = r+1 → `fm_wm[r][c]` = (r+1)(c+1), e.g. `fm_wm[5][2]` = 18.
- Overflow: all elements 31 → full sum 92256. Result 26720 without `TRANSFORM_SAT_EN`, 65535 with it.
- Start handling:
  - `start` pulses during FEAT are ignored: same results, same `done` time.
  - `start` in DONE drops `done` next edge and reruns with fresh data.
- Reset mid-run: reset asserted on the 5th FEAT cycle of column 1 → IDLE next edge, enables 0, all reads 0. A following full run gives correct results.
- Read port bounds: read row 6 / col 3 → 0. Read (5,2) after done → value on `fm_wm_rd_data` exactly one edge later.

Source files
------------

// File: rtl/gcn_pkg.sv
// ---------------------------------------------------------------------------
// gcn_pkg
// Shared definitions for the GCN blocks: default matrix dimensions (these
// must agree with the address counter), the transformation FSM state type,
// and a helper that gives the full-precision width of a dot product.
// No ports; import with gcn_pkg::*.
// ---------------------------------------------------------------------------
package gcn_pkg;

    localparam int GCN_FEATURE_ROWS   = 6;
    localparam int GCN_WEIGHT_COLS    = 3;
    localparam int GCN_FEATURE_COLS   = 96;
    localparam int GCN_DATA_WIDTH     = 5;
    localparam int GCN_DOT_PROD_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LATCH_W,
        FEAT,
        DRAIN,
        DONE
    } transform_state_t;

    // Width that holds a sum of num_terms unsigned data_width x data_width
    // products without loss.
    function automatic int full_prod_width(input int data_width, input int num_terms);
        return 2 * data_width + $clog2(num_terms);
    endfunction

endpackage

// File: rtl/dot_product_unit.sv
// ---------------------------------------------------------------------------
// dot_product_unit
// Combinational unsigned dot product of two packed vectors of FEATURE_COLS
// elements, reduced to DOT_PROD_WIDTH bits.
//
// Configuration macro: TRANSFORM_SAT_EN
//   defined     -> sums above 2^DOT_PROD_WIDTH-1 saturate to all ones
//   not defined -> the DOT_PROD_WIDTH LSBs of the sum are kept (wrap)
//
// Ports:
//   feature_vec  in   FEATURE_COLS*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   weight_vec   in   FEATURE_COLS*DATA_WIDTH  same packing as feature_vec
//   result       out  DOT_PROD_WIDTH           reduced dot product
// ---------------------------------------------------------------------------
module dot_product_unit
    import gcn_pkg::*;
#(
    parameter int FEATURE_COLS   = GCN_FEATURE_COLS,
    parameter int DATA_WIDTH     = GCN_DATA_WIDTH,
    parameter int DOT_PROD_WIDTH = GCN_DOT_PROD_WIDTH
) (
    input  logic [FEATURE_COLS*DATA_WIDTH-1:0] feature_vec,
    input  logic [FEATURE_COLS*DATA_WIDTH-1:0] weight_vec,
    output logic [DOT_PROD_WIDTH-1:0]          result
);

    localparam int FULL_WIDTH = full_prod_width(DATA_WIDTH, FEATURE_COLS);

    logic [FULL_WIDTH-1:0] full_sum;

    // Operands are widened to the full-precision width before multiplying so
    // no intermediate product or partial sum can lose bits; synthesis is free
    // to rebalance this chain into an adder tree.
    always_comb begin
        full_sum = '0;
        for (int i = 0; i < FEATURE_COLS; i++) begin
            full_sum = full_sum
                     + FULL_WIDTH'(feature_vec[i*DATA_WIDTH +: DATA_WIDTH])
                     * FULL_WIDTH'(weight_vec[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

`ifdef TRANSFORM_SAT_EN
    // The comparison is done in a width that fits both the sum and the
    // result limit, so it stays correct for any parameter combination.
    localparam int EXT_WIDTH = FULL_WIDTH + DOT_PROD_WIDTH;
    localparam logic [EXT_WIDTH-1:0] MAX_RESULT = EXT_WIDTH'({DOT_PROD_WIDTH{1'b1}});

    always_comb begin
        result = DOT_PROD_WIDTH'(full_sum);
        if (EXT_WIDTH'(full_sum) > MAX_RESULT) begin
            result = '1;
        end
    end
`else
    always_comb begin
        result = DOT_PROD_WIDTH'(full_sum);
    end
`endif

endmodule

// File: rtl/transformation_unit.sv
// ---------------------------------------------------------------------------
// transformation_unit
// Controller and datapath for FM_WM = FM * WM. For each weight column it
// fetches and latches the column, then streams every feature row through a
// dot_product_unit and stores the results in an on-block result buffer that
// the aggregation stage reads through a registered read port.
//
// Ports:
//   clk                     in   rising-edge clock
//   reset                   in   synchronous active-high, shared with the address counter
//   start                   in   single-cycle pulse, begins a full transformation
//   data_in                 in   memory read data, valid one cycle after its address
//   weight_count            in   weight column count from the address counter
//   read_row                in   feature row of the current data_in
//   enable_feature_counter  out  advance the counter's feature row
//   enable_weight_counter   out  advance the counter's weight column
//   read_feature_or_weight  out  1 = feature address, 0 = weight address
//   busy                    out  transformation in progress
//   done                    out  transformation complete, held until restart
//   fm_wm_rd_row/_col       in   result buffer read address
//   fm_wm_rd_data           out  result buffer read data, 1-cycle latency
// ---------------------------------------------------------------------------
module transformation_unit
    import gcn_pkg::*;
#(
    parameter int FEATURE_ROWS          = GCN_FEATURE_ROWS,
    parameter int WEIGHT_COLS           = GCN_WEIGHT_COLS,
    parameter int FEATURE_COLS          = GCN_FEATURE_COLS,
    parameter int DATA_WIDTH            = GCN_DATA_WIDTH,
    parameter int DOT_PROD_WIDTH        = GCN_DOT_PROD_WIDTH,
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [FEATURE_COLS*DATA_WIDTH-1:0] data_in,
    input  logic [COUNTER_WEIGHT_WIDTH-1:0]    weight_count,
    input  logic [COUNTER_FEATURE_WIDTH-1:0]   read_row,
    output logic                               enable_feature_counter,
    output logic                               enable_weight_counter,
    output logic                               read_feature_or_weight,
    output logic                               busy,
    output logic                               done,
    input  logic [COUNTER_FEATURE_WIDTH-1:0]   fm_wm_rd_row,
    input  logic [COUNTER_WEIGHT_WIDTH-1:0]    fm_wm_rd_col,
    output logic [DOT_PROD_WIDTH-1:0]          fm_wm_rd_data
);

    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  LAST_COL = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS - 1);

    transform_state_t state;
    transform_state_t next_state;

    logic [COUNTER_FEATURE_WIDTH-1:0]   row_cnt;
    logic [FEATURE_COLS*DATA_WIDTH-1:0] weight_reg;
    logic [COUNTER_WEIGHT_WIDTH-1:0]    col_idx;
    logic                               wr_pending;
    logic [DOT_PROD_WIDTH-1:0]          dot_result;
    logic [DOT_PROD_WIDTH-1:0]          fm_wm [FEATURE_ROWS][WEIGHT_COLS];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs. start only matters in IDLE and DONE;
    // there is no path back to IDLE other than reset.
    always_comb begin
        next_state             = state;
        enable_feature_counter = 1'b0;
        enable_weight_counter  = 1'b0;
        read_feature_or_weight = 1'b0;
        busy                   = 1'b0;
        done                   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD_W;
                end
            end
            LOAD_W: begin
                busy       = 1'b1;
                next_state = LATCH_W;
            end
            LATCH_W: begin
                busy                  = 1'b1;
                enable_weight_counter = 1'b1;
                next_state            = FEAT;
            end
            FEAT: begin
                busy                   = 1'b1;
                read_feature_or_weight = 1'b1;
                enable_feature_counter = 1'b1;
                if (row_cnt == LAST_ROW) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = (col_idx == LAST_COL) ? DONE : LOAD_W;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    next_state = LOAD_W;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Counts FEAT cycles; cleared while the weight column is latched so every
    // column gets exactly FEATURE_ROWS feature fetches.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
        end else if (state == LATCH_W) begin
            row_cnt <= '0;
        end else if (state == FEAT) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Weight column capture. wr_pending marks cycles whose data_in holds a
    // feature row requested on the previous cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            weight_reg <= '0;
            col_idx    <= '0;
            wr_pending <= 1'b0;
        end else begin
            wr_pending <= enable_feature_counter;
            if (state == LATCH_W) begin
                weight_reg <= data_in;
                col_idx    <= weight_count;
            end
        end
    end

    dot_product_unit #(
        .FEATURE_COLS   (FEATURE_COLS),
        .DATA_WIDTH     (DATA_WIDTH),
        .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
    ) u_dot_product (
        .feature_vec (data_in),
        .weight_vec  (weight_reg),
        .result      (dot_result)
    );

    // Result buffer and its registered read port. A read of an entry being
    // written on the same edge returns the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < FEATURE_ROWS; r++) begin
                for (int c = 0; c < WEIGHT_COLS; c++) begin
                    fm_wm[r][c] <= '0;
                end
            end
            fm_wm_rd_data <= '0;
        end else begin
            if (wr_pending && (read_row <= LAST_ROW) && (col_idx <= LAST_COL)) begin
                fm_wm[read_row][col_idx] <= dot_result;
            end
            if ((fm_wm_rd_row <= LAST_ROW) && (fm_wm_rd_col <= LAST_COL)) begin
                fm_wm_rd_data <= fm_wm[fm_wm_rd_row][fm_wm_rd_col];
            end else begin
                fm_wm_rd_data <= '0;
            end
        end
    end

endmodule
